reg_writeback_queue: RTL

REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

---
 rtl/reg_writeback_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/reg_writeback_queue.sv
// Register writeback queue: 4-entry FIFO merging ALU and load writebacks into one
// register-file write port, with pending-write read resolution. Optional macro: WB_FORWARD_EN.
module reg_writeback_queue (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [3:0]  alu_num,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [3:0]  mem_num,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic [3:0]  rd_num1,
  input  logic [3:0]  rd_num2,
  input  logic [31:0] rf_out1,
  input  logic [31:0] rf_out2,
  output logic        wr_en,
  output logic [3:0]  wr_num,
  output logic [31:0] wr_data,
  output logic [31:0] rd_data1,
  output logic [31:0] rd_data2,
  output logic        hazard,
  output logic        pc_redirect,
  output logic [2:0]  count,
  output logic        full,
  output logic        empty
);

  // Handshake: a request transfers at a rising edge where valid && ready; ready depends
  // only on the occupancy held before that edge (never on this cycle's dequeue), and
  // the ALU request claims a slot ahead of the load request.

  logic [3:0]  num_q  [4];
  logic [31:0] data_q [4];
  logic [1:0]  head;
  logic [1:0]  tail;
  logic [2:0]  cnt;
  logic [2:0]  free;
  logic        alu_acc;
  logic        mem_acc;
  logic        deq;
  logic [1:0]  n_enq;
  logic [1:0]  mem_slot;

  assign count = cnt;
  assign empty = (cnt == 3'd0);
  assign full  = (cnt == 3'd4);
  assign free  = 3'd4 - cnt;

  assign alu_ready = (free >= 3'd1);
  assign mem_ready = alu_valid ? (free >= 3'd2) : (free >= 3'd1);
  assign alu_acc   = alu_valid & alu_ready;
  assign mem_acc   = mem_valid & mem_ready;
  assign n_enq     = {1'b0, alu_acc} + {1'b0, mem_acc};
  assign mem_slot  = tail + {1'b0, alu_acc};

  assign deq     = ~empty;
  assign wr_en   = deq;
  assign wr_num  = empty ? 4'd0  : num_q[head];
  assign wr_data = empty ? 32'd0 : data_q[head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        num_q[i]  <= 4'd0;
        data_q[i] <= 32'd0;
      end
      head        <= 2'd0;
      tail        <= 2'd0;
      cnt         <= 3'd0;
      pc_redirect <= 1'b0;
    end else begin
      if (alu_acc) begin
        num_q[tail]  <= alu_num;
        data_q[tail] <= alu_data;
      end
      if (mem_acc) begin
        num_q[mem_slot]  <= mem_num;
        data_q[mem_slot] <= mem_data;
      end
      tail        <= tail + n_enq;
      head        <= head + {1'b0, deq};
      cnt         <= cnt + {1'b0, n_enq} - {2'b00, deq};
      pc_redirect <= deq && (num_q[head] == 4'd15);
    end
  end

  // The head entry still counts as pending during the cycle it is being written.
  logic       hit1;
  logic       hit2;
  logic [1:0] idx;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = head + 2'(i);
      if (3'(i) < cnt) begin
        if (num_q[idx] == rd_num1) hit1 = 1'b1;
        if (num_q[idx] == rd_num2) hit2 = 1'b1;
      end
    end
  end

`ifdef WB_FORWARD_EN
  logic [31:0] fwd1;
  logic [31:0] fwd2;
  logic [1:0]  fidx;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd1 = 32'd0;
    fwd2 = 32'd0;
    fidx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      fidx = head + 2'(i);
      if (3'(i) < cnt) begin
        if (num_q[fidx] == rd_num1) fwd1 = data_q[fidx];
        if (num_q[fidx] == rd_num2) fwd2 = data_q[fidx];
      end
    end
  end

  assign rd_data1 = hit1 ? fwd1 : rf_out1;
  assign rd_data2 = hit2 ? fwd2 : rf_out2;
  assign hazard   = 1'b0;
`else
  assign rd_data1 = rf_out1;
  assign rd_data2 = rf_out2;
  assign hazard   = hit1 | hit2;
`endif

endmodule
